grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
//  Sole owner of the GRF write port (RegWrite/WA/WD). Shares it between the W-stage pipeline writeback
//  and one late requester (multi-cycle MDU result / long-latency bus load).
//  Late writes go through a small FIFO. A per-register busy scoreboard goes to the hazard unit.
//  A starvation counter briefly freezes the pipeline so late writes cannot wait forever.
// PARAMETERS
//  DEPTH       2   late-write FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive cycles a valid FIFO head may lose before w_stall is asserted
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low (0 = in reset)
//  w_we       in   1   W-stage write request (cannot be back-pressured)
//  w_wa       in   5   W-stage destination
//  w_wd       in   32  W-stage data
//  w_stall    out  1   freeze pipeline this cycle (W-stage must hold and not present w_we)
//  rsv_valid  in   1   late op issued: reserve rsv_wa
//  rsv_wa     in   5   register to reserve
//  l_valid    in   1   late result valid
//  l_wa       in   5   late result destination
//  l_wd       in   32  late result data
//  l_ready    out  1   FIFO can accept (= !full)
//  gr_we      out  1   to GRF RegWrite
//  gr_wa      out  5   to GRF WA
//  gr_wd      out  32  to GRF WD
//  busy       out  32  bit i = register i has a reserved, uncommitted late write (bit 0 always 0)
//  err        out  1   sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (async, reset==0): FIFO empty, busy=0, starve count=0, err=0, w_stall=0, gr_we=0,
//    l_ready=0 while in reset. A reset mid-operation discards all pending late writes.
//  - Late accept: l_valid & l_ready at posedge -> {l_wa,l_wd} pushed. l_ready = count<DEPTH.
//    No accept-while-full, even if a pop happens in the same cycle.
//  - Port mux (combinational; GRF bypass covers same-cycle reads):
//    w_stall=1 -> FIFO head; else w_we -> W-stage; else FIFO non-empty -> head; else gr_we=0.
//  - Pop happens whenever the head drives the port. Minimum late latency is 1 cycle (accept edge,
//    commit next cycle).
//  - Register 0: any write with wa==0 has gr_we forced to 0. A late write to 0 is still accepted
//    and popped, but does not commit.
//  - Scoreboard: rsv_valid sets busy[rsv_wa] (ignored for wa 0). A pop of head wa clears busy[wa].
//    Same cycle, same reg, pop+rsv -> bit ends 1.
//  - Starvation: cnt increments each cycle the head is valid and a W write takes the port.
//    cnt clears on pop or when the FIFO is empty.
//    cnt==STARVE_MAX -> w_stall=1 for exactly one cycle (head pops), then cnt=0.
//  - err set (held until reset) on any of:
//    rsv to a busy reg without a same-cycle clearing pop;
//    w_we to a busy reg (WAW ordering violation);
//    late push whose wa is not busy (except 0);
//    l_valid while not ready is NOT an error: hold request.
//  - Outputs other than the gr_* mux and w_stall are registered.
// STRUCTURE
//  - Shared package/include: REG_AW=5, DATA_W=32, REG_ZERO=5'd0.
//  - One sub-module: wb_fifo (sync FIFO, DEPTH x 37 bits, push/pop/full/empty/count).
//    Scoreboard, starve counter and mux live in the top.
// TESTING
//  1 Reset mid-burst: 2 entries queued, busy=0x0000_0030, pull reset low -> FIFO empty, busy=0,
//    gr_we=0 immediately (async).
//  2 Idle late path: rsv $5, then push {5,0xDEAD_BEEF} with w_we=0 -> next cycle gr_we=1, gr_wa=5,
//    gr_wd=0xDEADBEEF; busy[5] clears.
//  3 Priority/starve: FIFO head $7, w_we=1 every cycle -> W owns the port 4 cycles, w_stall=1 on the
//    5th cycle with gr_wa=7, then W resumes.
//  4 Full FIFO: 2 pushes with W busy -> l_ready=0, a 3rd l_valid is held; after one pop,
//    l_ready=1 and it is accepted.
//  5 Zero/violations: push to $0 -> popped, gr_we=0, err=0. Then w_we to busy $9 -> err=1 and stays 1.
//  6 Same-cycle rsv+pop on $3 -> busy[3]=1, err=0.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared widths and the late-write payload carried through the arbiter FIFO.
package grf_wb_arbiter_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 1 << REG_AW;
    localparam int unsigned ENTRY_W  = REG_AW + DATA_W;

    localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

    // One queued late register write: destination plus data (ENTRY_W bits).
    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
    } late_wr_t;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Synchronous FIFO holding late register writes until they win the GRF port.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   i_push/i_din : write one entry (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_dout       : head entry (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy
module grf_wb_arbiter_wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  late_wr_t                     i_din,
    input  logic                         i_pop,
    output late_wr_t                     o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    late_wr_t          r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Owner of the GRF write port: muxes W-stage writeback and queued late writes,
// keeps the per-register busy scoreboard and breaks late-write starvation.
//   clk, reset          : clock, async active-low reset
//   w_we/w_wa/w_wd      : W-stage write (no back-pressure except w_stall)
//   w_stall             : combinational; freezes the pipeline for one late pop
//   rsv_valid/rsv_wa    : reserve a register for a future late write
//   l_valid/l_wa/l_wd   : late result request; l_ready = FIFO not full (registered)
//   gr_we/gr_wa/gr_wd   : combinational GRF write port
//   busy                : registered scoreboard; err : sticky protocol-violation flag
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_we,
    input  logic [REG_AW-1:0]     w_wa,
    input  logic [DATA_W-1:0]     w_wd,
    output logic                  w_stall,
    input  logic                  rsv_valid,
    input  logic [REG_AW-1:0]     rsv_wa,
    input  logic                  l_valid,
    input  logic [REG_AW-1:0]     l_wa,
    input  logic [DATA_W-1:0]     l_wd,
    output logic                  l_ready,
    output logic                  gr_we,
    output logic [REG_AW-1:0]     gr_wa,
    output logic [DATA_W-1:0]     gr_wd,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    late_wr_t            w_head;
    late_wr_t            w_din;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_next;
    logic                w_head_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_w_take;
    logic [NUM_REGS-1:0] w_busy_clr;
    logic [NUM_REGS-1:0] w_busy_set;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_err_rsv;
    logic                w_err_waw;
    logic                w_err_push;
    logic [SW-1:0]       r_starve;
    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;
    logic                r_l_ready;

    assign w_din.wa = l_wa;
    assign w_din.wd = l_wd;

    grf_wb_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Port arbitration: a starved head preempts W, otherwise W wins over the FIFO.
    always_comb begin
        w_head_valid = !w_empty;
        w_stall      = w_head_valid && (r_starve == SW'(STARVE_MAX));
        w_w_take     = w_we && !w_stall;
        w_pop        = w_head_valid && (w_stall || !w_we);
        w_push       = l_valid && r_l_ready && !w_full;
        gr_we        = 1'b0;
        gr_wa        = w_wa;
        gr_wd        = w_wd;
        if (w_pop) begin
            gr_we = (w_head.wa != REG_ZERO);
            gr_wa = w_head.wa;
            gr_wd = w_head.wd;
        end else if (w_w_take) begin
            gr_we = (w_wa != REG_ZERO);
        end
    end

    // Scoreboard update; a same-cycle reservation wins over the clearing pop.
    always_comb begin
        w_busy_clr = '0;
        w_busy_set = '0;
        if (w_pop)     w_busy_clr[w_head.wa] = 1'b1;
        if (rsv_valid) w_busy_set[rsv_wa]    = 1'b1;
        w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_next[0] = 1'b0;
    end

    // Protocol checks against the scoreboard as it stood before this edge.
    always_comb begin
        w_err_rsv  = rsv_valid && (rsv_wa != REG_ZERO) && r_busy[rsv_wa] &&
                     !(w_pop && (w_head.wa == rsv_wa));
        w_err_waw  = w_w_take && r_busy[w_wa];
        w_err_push = w_push && (l_wa != REG_ZERO) && !r_busy[l_wa];
    end

    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    // Head can only lose when W takes the port, so "not popped" implies a loss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve  <= SW'(0);
            r_busy    <= '0;
            r_err     <= 1'b0;
            r_l_ready <= 1'b0;
        end else begin
            if (!w_head_valid || w_pop) r_starve <= SW'(0);
            else                        r_starve <= r_starve + SW'(1);
            r_busy    <= w_busy_next;
            r_err     <= r_err | w_err_rsv | w_err_waw | w_err_push;
            r_l_ready <= (w_count_next < CW'(DEPTH));
        end
    end

    assign busy    = r_busy;
    assign err     = r_err;
    assign l_ready = r_l_ready;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: a queue-based reference model predicts
// every cycle's status and each committed GRF write; a monitor checks them.
module tb_grf_wb_arbiter;
    import grf_wb_arbiter_pkg::*;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct packed {
        logic        stall;
        logic        gr_we;
        logic        l_ready;
        logic [31:0] busy;
        logic        err;
    } status_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_we, rsv_valid, l_valid;
    logic [4:0]  w_wa, rsv_wa, l_wa;
    logic [31:0] w_wd, l_wd;
    logic        w_stall, l_ready, gr_we, err;
    logic [4:0]  gr_wa;
    logic [31:0] gr_wd, busy;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_stall(w_stall),
        .rsv_valid(rsv_valid), .rsv_wa(rsv_wa),
        .l_valid(l_valid), .l_wa(l_wa), .l_wd(l_wd), .l_ready(l_ready),
        .gr_we(gr_we), .gr_wa(gr_wa), .gr_wd(gr_wd), .busy(busy), .err(err)
    );

    // Reference model state
    late_wr_t    m_q[$];
    logic [31:0] m_busy;
    int          m_starve;
    logic        m_err, m_lready;
    bit          m_pushed;
    late_wr_t    exp_wr[$];
    status_t     exp_st[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy   = '0;
        m_starve = 0;
        m_err    = 1'b0;
        m_lready = 1'b0;
        m_pushed = 1'b0;
    endtask

    function automatic bit m_stall();
        return (m_q.size() > 0) && (m_starve == int'(STARVE_MAX));
    endfunction

    // One clock of stimulus; the model predicts this cycle and advances.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [4:0] rwa,
                         input logic lv, input logic [4:0] lwa, input logic [31:0] lwd);
        bit          stall, weff, pop, push;
        late_wr_t    e;
        status_t     st;
        logic [31:0] nb;
        @(negedge clk);
        w_we = we; w_wa = wa; w_wd = wd;
        rsv_valid = rv; rsv_wa = rwa;
        l_valid = lv; l_wa = lwa; l_wd = lwd;
        stall = m_stall();
        weff  = we && !stall;
        pop   = (m_q.size() > 0) && (stall || !we);
        push  = lv && m_lready;
        st.stall = stall; st.l_ready = m_lready; st.busy = m_busy; st.err = m_err;
        st.gr_we = 1'b0;
        if (pop) begin
            if (m_q[0].wa != 5'd0) begin
                st.gr_we = 1'b1;
                exp_wr.push_back(m_q[0]);
            end
        end else if (weff && wa != 5'd0) begin
            st.gr_we = 1'b1;
            e.wa = wa; e.wd = wd;
            exp_wr.push_back(e);
        end
        exp_st.push_back(st);
        if (rv && rwa != 5'd0 && m_busy[rwa] && !(pop && m_q[0].wa == rwa)) m_err = 1'b1;
        if (weff && wa != 5'd0 && m_busy[wa]) m_err = 1'b1;
        if (push && lwa != 5'd0 && !m_busy[lwa]) m_err = 1'b1;
        nb = m_busy;
        if (pop) nb[m_q[0].wa] = 1'b0;
        if (rv && rwa != 5'd0) nb[rwa] = 1'b1;
        m_busy = nb;
        if (pop) begin
            void'(m_q.pop_front());
            m_starve = 0;
        end else if (m_q.size() > 0 && weff) begin
            m_starve++;
        end
        if (m_q.size() == 0) m_starve = 0;
        if (push) begin
            e.wa = lwa; e.wd = lwd;
            m_q.push_back(e);
        end
        m_lready = (m_q.size() < int'(DEPTH));
        m_pushed = push;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gr_we"}, 32'(gr_we), 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_l_ready"}, 32'(l_ready), 32'd0);
        chk({tag, "_w_stall"}, 32'(w_stall), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic zero_inputs();
        w_we = 0; w_wa = 0; w_wd = 0; rsv_valid = 0; rsv_wa = 0;
        l_valid = 0; l_wa = 0; l_wd = 0;
    endtask

    // Monitor: per-cycle status compare, write compare whenever gr_we is seen.
    initial begin
        status_t  st;
        late_wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_st.size() > 0) begin
                st = exp_st.pop_front();
                chk("w_stall", 32'(w_stall), 32'(st.stall));
                chk("gr_we", 32'(gr_we), 32'(st.gr_we));
                chk("l_ready", 32'(l_ready), 32'(st.l_ready));
                chk("busy", busy, st.busy);
                chk("err", 32'(err), 32'(st.err));
                if (gr_we === 1'b1) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", 32'(gr_wa), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("gr_wa", 32'(gr_wa), 32'(e.wa));
                        chk("gr_wd", gr_wd, e.wd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we, rv, hv;
        logic [4:0]  wa, rwa, hwa;
        logic [31:0] wd, hwd;
        logic [4:0]  pend[$];
        bit          exp_stall[6];
        exp_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Idle late path: reserve $5, push, commit next cycle, busy clears
        idle();
        cycle(0, 5'd0, 32'd0, 1, 5'd5, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd5, 32'hDEAD_BEEF);
        idle();
        #2;
        chk("t2_gr_wa", 32'(gr_wa), 32'd5);
        chk("t2_gr_wd", gr_wd, 32'hDEAD_BEEF);
        idle();
        #2;
        chk("t2_busy5", 32'(busy[5]), 32'd0);

        // Starvation: head $7 against continuous W writes
        cycle(0, 5'd0, 32'd0, 1, 5'd7, 0, 5'd0, 32'd0);
        cycle(1, 5'd20, $urandom, 0, 5'd0, 1, 5'd7, 32'h0000_0777);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 5'd20, $urandom, 0, 5'd0, 0, 5'd0, 32'd0);
            #2;
            chk("t3_stall", 32'(w_stall), 32'(exp_stall[i]));
        end

        // Full FIFO: third request held until a pop frees space
        cycle(0, 5'd0, 32'd0, 1, 5'd10, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd11, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd12, 0, 5'd0, 32'd0);
        cycle(1, 5'd21, $urandom, 0, 5'd0, 1, 5'd10, 32'h1010_1010);
        cycle(1, 5'd21, $urandom, 0, 5'd0, 1, 5'd11, 32'h1111_1111);
        cycle(1, 5'd21, $urandom, 0, 5'd0, 1, 5'd12, 32'h1212_1212);
        #2;
        chk("t4_full_not_ready", 32'(l_ready), 32'd0);
        begin
            int n;
            n = 0;
            while (!m_pushed && n < 20) begin
                cycle(1, 5'd21, $urandom, 0, 5'd0, 1, 5'd12, 32'h1212_1212);
                n++;
            end
            if (!m_pushed) chk("t4_accept_timeout", 32'd1, 32'd0);
        end
        repeat (4) idle();

        // Same-cycle reservation and clearing pop on $3
        cycle(0, 5'd0, 32'd0, 1, 5'd3, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd3, 32'h0000_0333);
        cycle(0, 5'd0, 32'd0, 1, 5'd3, 0, 5'd0, 32'd0);
        idle();
        #2;
        chk("t6_busy3", 32'(busy[3]), 32'd1);
        chk("t6_err", 32'(err), 32'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd3, 32'h0000_3333);
        repeat (2) idle();

        // Randomized legal traffic
        hv = 0; hwa = 0; hwd = 0;
        for (int c = 0; c < 400; c++) begin
            we = !m_stall() && ($urandom_range(3, 0) != 0);
            wa = 5'($urandom_range(31, 0));
            for (int t = 0; t < 64 && m_busy[wa]; t++) wa = 5'($urandom_range(31, 0));
            if (m_busy[wa]) we = 0;
            wd = $urandom;
            rv = 0; rwa = 0;
            if (pend.size() < 3 && $urandom_range(2, 0) == 0) begin
                rwa = 5'($urandom_range(31, 1));
                for (int t = 0; t < 64 && m_busy[rwa]; t++) rwa = 5'($urandom_range(31, 1));
                rv = !m_busy[rwa];
            end
            if (!hv) begin
                if (pend.size() > 0 && $urandom_range(1, 0) == 1) begin
                    hv = 1; hwa = pend.pop_front(); hwd = $urandom;
                end else if ($urandom_range(15, 0) == 0) begin
                    hv = 1; hwa = 5'd0; hwd = $urandom;
                end
            end
            cycle(we, wa, wd, rv, rwa, hv, hwa, hwd);
            if (m_pushed) hv = 0;
            if (rv) pend.push_back(rwa);
        end
        for (int c = 0; c < 60 && (hv || pend.size() > 0 || m_q.size() > 0); c++) begin
            if (!hv && pend.size() > 0) begin
                hv = 1; hwa = pend.pop_front(); hwd = $urandom;
            end
            cycle(0, 5'd0, 32'd0, 0, 5'd0, hv, hwa, hwd);
            if (m_pushed) hv = 0;
        end
        idle();
        #2;
        chk("rand_busy_drained", busy, 32'd0);
        chk("rand_err_clean", 32'(err), 32'd0);

        // Register 0 late write, then a WAW violation on busy $9
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd0, 32'h0BAD_0000);
        idle();
        #2;
        chk("t5_zero_gr_we", 32'(gr_we), 32'd0);
        chk("t5_zero_err", 32'(err), 32'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd9, 0, 5'd0, 32'd0);
        cycle(1, 5'd9, 32'h9999_9999, 0, 5'd0, 0, 5'd0, 32'd0);
        idle();
        #2;
        chk("t5_err_set", 32'(err), 32'd1);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd9, 32'h0909_0909);
        repeat (2) idle();
        #2;
        chk("t5_err_sticky", 32'(err), 32'd1);

        // Reset mid-burst with two queued entries
        cycle(0, 5'd0, 32'd0, 1, 5'd4, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd5, 0, 5'd0, 32'd0);
        cycle(1, 5'd22, $urandom, 0, 5'd0, 1, 5'd4, 32'h4444_4444);
        cycle(1, 5'd22, $urandom, 0, 5'd0, 1, 5'd5, 32'h5555_5555);
        cycle(1, 5'd22, $urandom, 0, 5'd0, 0, 5'd0, 32'd0);
        #2;
        chk("t1_busy_before", busy, 32'h0000_0030);
        #1;
        reset = 1'b0;
        zero_inputs();
        #1;
        check_reset_outputs("t1");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;

        // Recovery after reset
        idle();
        cycle(0, 5'd0, 32'd0, 1, 5'd6, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 1, 5'd6, 32'h6666_6666);
        repeat (2) idle();

        @(negedge clk);
        #3;
        chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
        chk("leftover_status", 32'(exp_st.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
